ex8_light_sequencer: RTL

//  Initiator for the EX8 delay timer: drives its N/trigger inputs and consumes
//  its time_out. On start it lights STEPS LEDs one per timer expiry, then holds
//  for a random (LFSR-supplied) interval, clears the LEDs and pulses done.

---
 rtl/ex8_light_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ex8_light_sequencer.sv
// ex8_light_sequencer
//   Initiator for the EX8 delay timer. On start it lights STEPS LEDs, one per
//   timer expiry, then holds for a random (LFSR-supplied) interval, clears the
//   LEDs and pulses done for one cycle.
//
// Ports
//   clk       in   1      system clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      level; sampled only in IDLE
//   rand_n    in   13     random hold count, sampled when the last LED lights
//   time_out  in   1      timer expiry; sticky until trigger drops
//   n_out     out  13     count value for the timer N input
//   trigger   out  1      timer run enable
//   ledr      out  STEPS  light bar, bit 0 lights first
//   busy      out  1      sequence in progress
//   done      out  1      one-cycle pulse at end of sequence
module ex8_light_sequencer #(
    parameter int unsigned STEPS  = 5,
    parameter logic [12:0] STEP_N = 13'd1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [12:0]      rand_n,
    input  logic             time_out,
    output logic [12:0]      n_out,
    output logic             trigger,
    output logic [STEPS-1:0] ledr,
    output logic             busy,
    output logic             done
);

    localparam int unsigned STEP_W = $clog2(STEPS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStepRun,
        StStepRearm,
        StHoldRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [STEPS-1:0]   ledr_q, ledr_d;
    logic [12:0]        n_out_q, n_out_d;
    logic [12:0]        hold_n_q, hold_n_d;
    logic               trigger_q, trigger_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rearm_q, rearm_d;
    logic [12:0]        hold_val;

    // N=0 would make the timer wrap through 8191 counts.
    assign hold_val = (rand_n == 13'd0) ? 13'd1 : rand_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= '0;
            ledr_q    <= '0;
            n_out_q   <= STEP_N;
            hold_n_q  <= 13'd1;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rearm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            ledr_q    <= ledr_d;
            n_out_q   <= n_out_d;
            hold_n_q  <= hold_n_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rearm_q   <= rearm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ledr_d    = ledr_q;
        n_out_d   = n_out_q;
        hold_n_d  = hold_n_q;
        trigger_d = trigger_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rearm_d   = rearm_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StStepRun;
                    n_out_d   = STEP_N;
                    trigger_d = 1'b1;
                    step_d    = '0;
                    ledr_d    = '0;
                    busy_d    = 1'b1;
                end
            end

            StStepRun: begin
                if (time_out) begin
                    ledr_d    = ledr_q << 1;
                    ledr_d[0] = 1'b1;
                    step_d    = step_q + STEP_W'(1);
                    // Drop trigger so the timer clears count and time_out.
                    trigger_d = 1'b0;
                    if (step_q == STEP_W'(STEPS - 1)) begin
                        state_d  = StHoldRun;
                        hold_n_d = hold_val;
                        n_out_d  = hold_val;
                        rearm_d  = 1'b1;
                    end else begin
                        state_d = StStepRearm;
                    end
                end
            end

            StStepRearm: begin
                // time_out may still be stale here; it is ignored.
                state_d   = StStepRun;
                trigger_d = 1'b1;
            end

            StHoldRun: begin
                if (rearm_q) begin
                    rearm_d   = 1'b0;
                    trigger_d = 1'b1;
                    n_out_d   = hold_n_q;
                end else if (time_out) begin
                    state_d   = StDone;
                    trigger_d = 1'b0;
                    ledr_d    = '0;
                    // busy falls together with the done pulse.
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
                step_d  = '0;
            end

            default: begin
                state_d   = StIdle;
                trigger_d = 1'b0;
                busy_d    = 1'b0;
                ledr_d    = '0;
            end
        endcase
    end

    assign n_out   = n_out_q;
    assign trigger = trigger_q;
    assign ledr    = ledr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
